// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: the instruction-phase state
// encoding and the PC value that requests a CPU halt.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC1  = 3'd2,
    EXEC2  = 3'd3,
    HALTED = 3'd4
  } phase_state_t;

  // A jump to this address ends execution after the current instruction
  localparam logic [31:0] HALT_PC = 32'h0000_0000;

endpackage : mips_cpu_pkg

// File: rtl/mem_phase_ctrl.sv
// Instruction-phase sequencer: steps FETCH/EXEC1/EXEC2, holds on memory stalls,
// latches instruction and load data, and generates PC-advance/commit strobes.
module mem_phase_ctrl
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_halt,
  input  logic        needs_exec2,
  input  logic        halt_req,
  input  logic [31:0] readdata,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [31:0] instr_reg,
  output logic [31:0] load_data,
  output logic        pc_en,
  output logic        commit,
  output logic        active,
  output logic [15:0] stall_cycles
);

  phase_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  load_q, load_d;
  logic         active_q;
  logic [15:0]  stall_q;
  logic         commit_c;
  logic         stalled;

  // Only FETCH and EXEC1 issue memory accesses, so only they can stall
  assign stalled = mem_halt && ((state_q == FETCH) || (state_q == EXEC1));

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    load_d   = load_q;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!mem_halt) begin
          instr_d = readdata;
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        if (!mem_halt) begin
          load_d = readdata;
          if (needs_exec2) begin
            state_d = EXEC2;
          end else begin
            commit_c = 1'b1;
            state_d  = halt_req ? HALTED : FETCH;
          end
        end
      end
      EXEC2: begin
        commit_c = 1'b1;
        state_d  = halt_req ? HALTED : FETCH;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= 32'h0;
      load_q   <= 32'h0;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      load_q   <= load_d;
      active_q <= (state_d != HALTED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0;
    end else if (stalled && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign fetch        = (state_q == FETCH);
  assign exec1        = (state_q == EXEC1);
  assign exec2        = (state_q == EXEC2);
  assign instr_reg    = instr_q;
  assign load_data    = load_q;
  assign pc_en        = commit_c;
  assign commit       = commit_c;
  assign active       = active_q;
  assign stall_cycles = stall_q;

endmodule : mem_phase_ctrl

// File: tb/tb_mem_phase_ctrl.sv
// Directed bench for mem_phase_ctrl with hand-computed expectations.
module tb_mem_phase_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_halt;
  logic        needs_exec2;
  logic        halt_req;
  logic [31:0] readdata;
  logic        fetch;
  logic        exec1;
  logic        exec2;
  logic [31:0] instr_reg;
  logic [31:0] load_data;
  logic        pc_en;
  logic        commit;
  logic        active;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  mem_phase_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_halt     (mem_halt),
    .needs_exec2  (needs_exec2),
    .halt_req     (halt_req),
    .readdata     (readdata),
    .fetch        (fetch),
    .exec1        (exec1),
    .exec2        (exec2),
    .instr_reg    (instr_reg),
    .load_data    (load_data),
    .pc_en        (pc_en),
    .commit       (commit),
    .active       (active),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] phase();
    return {29'b0, fetch, exec1, exec2};
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_phase"}, phase(), 32'h0);
    check_eq({tag, "_instr"}, instr_reg, 32'h0);
    check_eq({tag, "_load"}, load_data, 32'h0);
    check_eq({tag, "_stall"}, {16'h0, stall_cycles}, 32'h0);
    check_eq({tag, "_active"}, {31'h0, active}, 32'h1);
    check_eq({tag, "_pcen_commit"}, {30'h0, pc_en, commit}, 32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_halt    = 1'b0;
    needs_exec2 = 1'b0;
    halt_req    = 1'b0;
    readdata    = 32'h8C01_0004;
    tick();
    tick();
    check_reset_vals("rst");

    // Basic two-cycle instruction
    rst_n = 1'b1;
    tick();
    check_eq("c1_phase", phase(), 32'h4);
    tick();
    check_eq("c2_phase", phase(), 32'h2);
    check_eq("c2_instr", instr_reg, 32'h8C01_0004);
    check_eq("c2_pcen_commit", {30'h0, pc_en, commit}, 32'h3);
    tick();
    check_eq("c3_phase", phase(), 32'h4);
    check_eq("c3_load", load_data, 32'h8C01_0004);
    check_eq("c3_commit", {31'h0, commit}, 32'h0);

    // Three stalled FETCH edges
    mem_halt = 1'b1;
    readdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_phase", phase(), 32'h4);
      check_eq("stall_instr", instr_reg, 32'h8C01_0004);
    end
    check_eq("stall_cnt3", {16'h0, stall_cycles}, 32'd3);
    mem_halt    = 1'b0;
    readdata    = 32'h2222_2222;
    needs_exec2 = 1'b1;
    halt_req    = 1'b1;
    tick();
    check_eq("fetch4_phase", phase(), 32'h2);
    check_eq("fetch4_instr", instr_reg, 32'h2222_2222);
    check_eq("e1_no_commit", {30'h0, pc_en, commit}, 32'h0);
    check_eq("stall_hold", {16'h0, stall_cycles}, 32'd3);

    // EXEC2 load path, halting at its commit
    readdata = 32'hDEAD_BEEF;
    tick();
    check_eq("e2_phase", phase(), 32'h1);
    check_eq("e2_load", load_data, 32'hDEAD_BEEF);
    check_eq("e2_pcen_commit", {30'h0, pc_en, commit}, 32'h3);
    check_eq("e2_active", {31'h0, active}, 32'h1);
    tick();
    check_eq("halt_phase", phase(), 32'h0);
    check_eq("halt_active", {31'h0, active}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      mem_halt    = 1'($urandom);
      needs_exec2 = 1'($urandom);
      halt_req    = 1'($urandom);
      readdata    = $urandom;
      tick();
      check_eq("hf_phase", phase(), 32'h0);
      check_eq("hf_active", {31'h0, active}, 32'h0);
      check_eq("hf_commit", {30'h0, pc_en, commit}, 32'h0);
      check_eq("hf_instr", instr_reg, 32'h2222_2222);
      check_eq("hf_load", load_data, 32'hDEAD_BEEF);
      check_eq("hf_stall", {16'h0, stall_cycles}, 32'd3);
    end

    // Reset in the middle of an EXEC1 stall
    rst_n       = 1'b0;
    mem_halt    = 1'b0;
    needs_exec2 = 1'b0;
    halt_req    = 1'b0;
    readdata    = 32'h3333_3333;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("r2_e1", phase(), 32'h2);
    mem_halt = 1'b1;
    readdata = 32'h5555_5555;
    tick();
    tick();
    check_eq("r2_e1_hold", phase(), 32'h2);
    check_eq("r2_load_hold", load_data, 32'h0);
    check_eq("r2_stall2", {16'h0, stall_cycles}, 32'd2);
    check_eq("r2_no_commit", {31'h0, commit}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    mem_halt = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rel_idle", phase(), 32'h0);
    tick();
    check_eq("rel_fetch", phase(), 32'h4);
    check_eq("rel_stall", {16'h0, stall_cycles}, 32'h0);

    // Long stall in FETCH to hit saturation
    mem_halt = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check_eq("sat_fffe", {16'h0, stall_cycles}, 32'h0000_FFFE);
    tick();
    check_eq("sat_ffff", {16'h0, stall_cycles}, 32'h0000_FFFF);
    for (int i = 0; i < 4465; i++) tick();
    check_eq("sat_hold", {16'h0, stall_cycles}, 32'h0000_FFFF);
    check_eq("sat_phase", phase(), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_phase_ctrl
